formula_result_fifo: RTL and testbench
======================================

FORMULA_RESULT_FIFO -- requirements
Module: formula_result_fifo

Interface
REQ-001 The block SHALL have parameter W, default 32, as the result data width.
REQ-002 The block SHALL have parameter DEPTH, default 8, as the number of result storage entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port up_vld, input, 1 bit: the upstream source offers an argument set.
REQ-006 The block SHALL have port up_rdy, output, 1 bit: a credit is available and the offer is accepted.
REQ-007 The block SHALL have port arg_vld, output, 1 bit: the issue strobe to the formula pipe's arg_vld.
REQ-008 The block SHALL have port res_vld, input, 1 bit: result valid from the formula pipe.
REQ-009 The block SHALL have port res, input, W bits: result data from the formula pipe.
REQ-010 The block SHALL have port out_vld, output, 1 bit: the head result is available to the consumer.
REQ-011 The block SHALL have port out_rdy, input, 1 bit: the consumer accepts the head result.
REQ-012 The block SHALL have port out_data, output, W bits: the head result.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky error flag.

Function
REQ-014 up_rdy SHALL equal (credits_used < DEPTH); credits_used is the count of issued arguments whose results have not yet been popped.
REQ-015 arg_vld SHALL equal up_vld & up_rdy, combinationally, so the formula pipe never receives more in-flight work than DEPTH.
REQ-016 credits_used SHALL increment on arg_vld, decrement on pop (out_vld & out_rdy), and hold when both or neither occur in the same cycle.
REQ-017 On a cycle with res_vld=1 and the storage not full, res SHALL be written at the write pointer.
REQ-018 out_vld SHALL be 1 whenever the storage is non-empty, and out_data SHALL be the oldest entry.
REQ-019 out_data SHALL be driven from registered storage with no combinational path from res; the minimum res-to-out latency is 1 cycle.
REQ-020 Push and pop in the same cycle SHALL be allowed at any occupancy from 1 to DEPTH, and the occupancy SHALL be unchanged.
REQ-021 Pointers SHALL be log2(DEPTH) bits wide, wrap modulo DEPTH, and use an extra wrap bit (or an occupancy counter) to distinguish full from empty.
REQ-022 When the storage is empty, a pop SHALL be impossible (out_vld=0), and out_rdy SHALL be ignored.
REQ-023 If res_vld=1 while the storage is full and no pop occurs in that cycle, the data SHALL be dropped and overflow SHALL be set and held until reset.
REQ-024 The order of results SHALL be preserved first-in, first-out, with no loss or duplication.
REQ-025 Stored data registers SHALL be written only on a push, to save dynamic power.
REQ-026 The credit scheme SHALL make the block independent of the formula pipe latency; no latency parameter is required.

Reset
REQ-027 While rst=0 at a rising clk edge, the following SHALL be cleared: credits_used, the pointers or occupancy, and overflow.
REQ-028 During and after reset, the outputs SHALL be: out_vld=0, up_rdy=1 (after reset), arg_vld=up_vld, overflow=0.
REQ-029 out_data and the storage array SHALL NOT be reset.
REQ-030 A reset taken while results are in flight SHALL discard them; results that arrive after reset are the responsibility of the system, which resets the formula pipe in the same cycle.

Structure
REQ-031 The shared package formula_pkg SHALL hold the default W and DEPTH constants.
REQ-032 The block SHALL instantiate one sub-module, flop_fifo, which implements the storage, pointers, full/empty and overflow; the credit counter SHALL stay at top level.

Verification
REQ-033 The bench SHALL cover this scenario: reset, then up_vld=1 held for 10 cycles with out_rdy=0 and DEPTH=8 -> exactly 8 arg_vld pulses, up_rdy=0 from the 9th cycle, and no overflow.
REQ-034 The bench SHALL cover this scenario: with the FIFO full at 8, drive out_rdy=1 for one cycle -> one pop, then up_rdy=1 and one new issue in the next cycle.
REQ-035 The bench SHALL cover this scenario: a back-to-back stream of 100 issues with out_rdy=1 continuously through formula_1_pipe, where a=b=c=k*k -> out_data=3k in order, at full throughput after fill.
REQ-036 The bench SHALL cover this scenario: a random out_rdy (50%) with random up_vld over 10,000 cycles -> the scoreboard matches, overflow=0, and credits_used never exceeds 8.
REQ-037 The bench SHALL cover this scenario: force res_vld=1 with the storage full and out_rdy=0 -> overflow=1 and it stays 1 until rst=0.
REQ-038 The bench SHALL cover this scenario: assert rst=0 with 5 entries stored -> out_vld=0 on the next cycle and up_rdy=1.

Source files
------------

// File: rtl/formula_pkg.sv
`timescale 1ns/1ps
// Shared constants for the formula result path: default result width and
// default result storage depth used by formula_result_fifo and flop_fifo.
package formula_pkg;

  // Width of one formula result word.
  localparam int FORMULA_W     = 32;
  // Number of result slots; must be a power of two and at least 2.
  localparam int FORMULA_DEPTH = 8;

endpackage

// File: rtl/flop_fifo.sv
`timescale 1ns/1ps
// Flop-based result FIFO: storage array, read/write pointers with a wrap bit,
// empty/full decode and a sticky overflow flag for pushes that find no room.
//
// Handshake: a push is taken on any cycle with i_push=1 when the FIFO is not
// full, or when it is full but a pop happens in the same cycle. A pop is taken
// on any cycle with i_pop=1 and o_vld=1; i_pop is ignored while empty. o_data
// always shows the oldest entry and only changes on a clock edge.
module flop_fifo
  import formula_pkg::*;
#(
  parameter int W     = FORMULA_W,
  parameter int DEPTH = FORMULA_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_data,
  output logic         o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so equal low bits can mean either
  // empty (wrap bits equal) or full (wrap bits differ).
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop while empty is meaningless and is discarded here.
  assign w_pop  = i_pop & ~w_empty;
  // When full, a simultaneous pop frees the head slot, so the push still fits.
  assign w_push = i_push & (~w_full | w_pop);
  // A push against a full FIFO with no pop is lost and flagged.
  assign w_drop = i_push & w_full & ~w_pop;

  assign o_vld      = ~w_empty;
  assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  // Pointer update: advance on accepted push/pop, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
    end
  end

  // Storage write: only on an accepted push, never reset (data is don't-care
  // until the matching pointer marks it valid).
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Sticky overflow: set on a dropped push, held until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/formula_result_fifo.sv
`timescale 1ns/1ps
// Credit-gated result buffer for a formula pipe of unknown latency.
//
// Handshake: upstream offers work with up_vld; the offer is taken in the same
// cycle when up_rdy=1, which is also when arg_vld pulses to the formula pipe.
// up_rdy is 1 while fewer than DEPTH issued arguments still have a result that
// has not left through the output. Every issued argument therefore has a
// guaranteed slot, whatever the pipe latency. Results arrive on res_vld/res
// and are buffered; the consumer takes the head with out_vld & out_rdy.
module formula_result_fifo
  import formula_pkg::*;
#(
  parameter int W     = FORMULA_W,
  parameter int DEPTH = FORMULA_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  output logic         arg_vld,
  input  logic         res_vld,
  input  logic [W-1:0] res,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_CRED_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_CRED_ONE = (AW+1)'(1);

  // Count of issued arguments whose results have not yet been popped;
  // ranges 0..DEPTH, hence the extra bit.
  logic [AW:0] r_credits;
  logic        w_pop;

  assign up_rdy  = (r_credits < LP_CRED_MAX);
  assign arg_vld = up_vld & up_rdy;
  assign w_pop   = out_vld & out_rdy;

  // Credit counter: +1 per issue, -1 per pop, hold when both or neither.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_credits <= '0;
    end else begin
      case ({arg_vld, w_pop})
        2'b10:   r_credits <= r_credits + LP_CRED_ONE;
        2'b01:   r_credits <= r_credits - LP_CRED_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  flop_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (res_vld),
    .i_data     (res),
    .i_pop      (w_pop),
    .o_vld      (out_vld),
    .o_data     (out_data),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_formula_result_fifo.sv
`timescale 1ns/1ps
// Bench for formula_result_fifo: a fixed-latency formula pipe model computes
// sqrt(a)+sqrt(b)+sqrt(c) with a=b=c=k*k; the scoreboard expects 3k per issue.
module tb_formula_result_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int L     = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         up_vld  = 1'b0;
  logic         out_rdy = 1'b0;
  logic         up_rdy;
  logic         arg_vld;
  logic         res_vld;
  logic [W-1:0] res;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         overflow;

  formula_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_vld   (up_vld),
    .up_rdy   (up_rdy),
    .arg_vld  (arg_vld),
    .res_vld  (res_vld),
    .res      (res),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .overflow (overflow)
  );

  // ---------------- formula pipe model ----------------
  int unsigned  cur_k     = 0;
  logic         force_res = 1'b0;
  logic [L-1:0] pv;
  logic [W-1:0] pd [L];

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    for (int b = 15; b >= 0; b--) begin
      int unsigned t = r | (32'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] formula_1(input int unsigned k);
    int unsigned a = k * k;
    int unsigned b = k * k;
    int unsigned c = k * k;
    return W'(isqrt(a) + isqrt(b) + isqrt(c));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[L-2:0], arg_vld};
      pd[0] <= formula_1(cur_k);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end

  assign res_vld = pv[L-1] | force_res;
  assign res     = force_res ? 32'hDEAD_BEEF : pd[L-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int model_cred = 0;
  int cyc        = 0;
  int pop_cnt    = 0;
  int first_pop  = -1;
  int last_pop   = -1;
  logic s_up_rdy, s_arg_vld, s_out_vld, s_overflow, s_pop;

  task automatic check_eq(input string tag, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, score, then return at posedge+1.
  task automatic step();
    logic exp_rdy;
    logic exp_arg;
    @(negedge clk);
    s_up_rdy   = up_rdy;
    s_arg_vld  = arg_vld;
    s_out_vld  = out_vld;
    s_overflow = overflow;
    s_pop      = out_vld & out_rdy;
    if (rst) begin
      exp_rdy = (model_cred < DEPTH);
      exp_arg = up_vld & exp_rdy;
      check_eq("up_rdy", W'(up_rdy), W'(exp_rdy));
      check_eq("arg_vld", W'(arg_vld), W'(exp_arg));
      if (arg_vld) exp_q.push_back(W'(3 * cur_k));
      if (s_pop) begin
        if (exp_q.size() == 0) begin
          check_eq("out_vld_when_empty", W'(out_vld), '0);
        end else begin
          check_eq("out_data", out_data, exp_q.pop_front());
          pop_cnt++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
      model_cred += int'(exp_arg) - int'(s_pop);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Empty the FIFO with out_rdy=1 under a cycle budget.
  task automatic drain(input string tag);
    int n = 0;
    up_vld  = 1'b0;
    out_rdy = 1'b1;
    while ((exp_q.size() != 0 || out_vld) && n < 500) begin
      step();
      n++;
    end
    check_eq({tag, "_queue_empty"}, W'(exp_q.size()), '0);
    check_eq({tag, "_out_vld"}, W'(out_vld), '0);
    out_rdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int arg_cnt;
    int issues;
    int n;

    // Reset with up_vld high: arg_vld must follow up_vld.
    rst = 1'b0; up_vld = 1'b1; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_vld", W'(out_vld), '0);
    check_eq("rst_up_rdy", W'(up_rdy), 1);
    check_eq("rst_arg_vld", W'(arg_vld), W'(up_vld));
    check_eq("rst_overflow", W'(overflow), '0);
    @(posedge clk); #1;
    rst = 1'b1; up_vld = 1'b0; out_rdy = 1'b0;
    model_cred = 0;
    exp_q.delete();

    // Fill: 10 cycles of up_vld with no consumer.
    arg_cnt = 0;
    cur_k   = 5;
    up_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_arg_vld) arg_cnt++;
      if (i == 8) check_eq("fill_rdy_9th", W'(s_up_rdy), '0);
    end
    check_eq("fill_arg_pulses", W'(arg_cnt), 8);
    up_vld = 1'b0;
    repeat (6) step();
    check_eq("fill_out_vld", W'(out_vld), 1);
    check_eq("fill_overflow", W'(overflow), '0);

    // One pop from full frees exactly one credit.
    cur_k = 9; up_vld = 1'b1; out_rdy = 1'b1;
    step();
    check_eq("full_pop_rdy", W'(s_up_rdy), '0);
    check_eq("full_pop_taken", W'(s_pop), 1);
    out_rdy = 1'b0;
    step();
    check_eq("after_pop_rdy", W'(s_up_rdy), 1);
    check_eq("after_pop_issue", W'(s_arg_vld), 1);
    step();
    check_eq("refull_rdy", W'(s_up_rdy), '0);
    drain("full_pop");

    // Back-to-back stream of 100 issues, consumer always ready.
    out_rdy = 1'b1; issues = 0; pop_cnt = 0; first_pop = -1; last_pop = -1;
    for (int k = 1; k <= 100; k++) begin
      cur_k  = k;
      up_vld = 1'b1;
      step();
      if (s_arg_vld) issues++;
    end
    check_eq("stream_issues", W'(issues), 100);
    drain("stream");
    check_eq("stream_pops", W'(pop_cnt), 100);
    check_eq("stream_throughput", W'(last_pop - first_pop), 99);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      up_vld  = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      cur_k   = $urandom_range(0, 1000);
      step();
    end
    drain("random");
    check_eq("random_overflow", W'(overflow), '0);

    // Forced result into a full FIFO sets a sticky overflow.
    cur_k = 11; up_vld = 1'b1; out_rdy = 1'b0;
    repeat (10) step();
    up_vld = 1'b0;
    repeat (6) step();
    check_eq("ovf_full_vld", W'(out_vld), 1);
    check_eq("ovf_pre", W'(overflow), '0);
    force_res = 1'b1;
    step();
    force_res = 1'b0;
    step();
    check_eq("ovf_set", W'(s_overflow), 1);
    repeat (5) step();
    check_eq("ovf_sticky", W'(overflow), 1);

    // Pop three (dropped word must not appear), then reset with 5 stored.
    out_rdy = 1'b1; pop_cnt = 0; n = 0;
    while (pop_cnt < 3 && n < 20) begin
      step();
      n++;
    end
    out_rdy = 1'b0;
    check_eq("pre_rst_pops", W'(pop_cnt), 3);
    check_eq("pre_rst_overflow", W'(overflow), 1);
    check_eq("pre_rst_out_vld", W'(out_vld), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_out_vld", W'(out_vld), '0);
    check_eq("mid_rst_up_rdy", W'(up_rdy), 1);
    check_eq("mid_rst_overflow", W'(overflow), '0);
    rst = 1'b1;
    exp_q.delete();
    model_cred = 0;

    // Single issue after reset goes through cleanly.
    cur_k = 7; up_vld = 1'b1;
    step();
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Run-time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
